// File: rtl/shiftreg_pkg.sv
// Shared definitions for the shiftreg serial link (s2p receiver, p2s transmitter).
package shiftreg_pkg;

    localparam int unsigned WORD_W = 8;

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

endpackage

// File: rtl/s2p_bitcnt.sv
// Modulo-N bit counter with sync clear; wrap flags the bit that completes a word.
module s2p_bitcnt #(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync,
    output logic [$clog2(N)-1:0] cnt,
    output logic                 wrap
);

    localparam int unsigned   CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] base;
    logic [CW-1:0] cnt_next;

    // sync restarts counting before the current bit is counted
    always_comb begin
        base     = sync ? '0 : cnt;
        wrap     = en && (base == LAST);
        cnt_next = base;
        if (en) begin
            cnt_next = wrap ? '0 : base + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/shiftreg_s2p.sv
// Serial-to-parallel deserializer with sync alignment, one-word output buffer
// and a sticky overrun flag.
module shiftreg_s2p
    import shiftreg_pkg::*;
#(
    parameter int unsigned N         = WORD_W,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sin,
    input  logic                 sin_en,
    input  logic                 sync,
    output logic [N-1:0]         pout,
    output logic                 pout_valid,
    input  logic                 pout_ready,
    output logic                 overrun,
    input  logic                 ovr_clr,
    output logic [$clog2(N)-1:0] bit_cnt
);

    logic [N-1:0] shreg;
    logic [N-1:0] shreg_base;
    logic [N-1:0] shreg_next;
    logic         done;
    logic         load;
    logic         drop;
    buf_state_t   state;
    buf_state_t   state_next;

    s2p_bitcnt #(.N(N)) u_bitcnt (
        .clk  (clk),
        .rst  (rst),
        .en   (sin_en),
        .sync (sync),
        .cnt  (bit_cnt),
        .wrap (done)
    );

    always_comb begin
        shreg_base = sync ? '0 : shreg;
        shreg_next = shreg;
        if (sin_en) begin
            if (MSB_FIRST) begin
                shreg_next = {shreg_base[N-2:0], sin};
            end else begin
                shreg_next = {sin, shreg_base[N-1:1]};
            end
        end
    end

    // a completing word is loaded unless the buffer is full and not being drained
    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        unique case (state)
            BUF_EMPTY: begin
                if (done) begin
                    state_next = BUF_FULL;
                    load       = 1'b1;
                end
            end
            BUF_FULL: begin
                if (pout_ready) begin
                    if (done) begin
                        load = 1'b1;
                    end else begin
                        state_next = BUF_EMPTY;
                    end
                end else if (done) begin
                    drop = 1'b1;
                end
            end
            default: state_next = BUF_EMPTY;
        endcase
    end

    assign pout_valid = (state == BUF_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= BUF_EMPTY;
            shreg   <= '0;
            pout    <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            if (load) begin
                pout <= shreg_next;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shiftreg_s2p.sv
// Directed bench for shiftreg_s2p: MSB-first and LSB-first instances driven in
// parallel, completed words checked against a scoreboard queue.
module tb_shiftreg_s2p;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b0;
    logic       sin_en = 1'b0;
    logic       sync = 1'b0;
    logic       pout_ready = 1'b1;
    logic       ovr_clr = 1'b0;
    logic [7:0] pout_m, pout_l;
    logic       valid_m, valid_l, ovr_m, ovr_l;
    logic [2:0] cnt_m, cnt_l;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];

    always #5 clk = ~clk;

    shiftreg_s2p #(.N(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sync(sync),
        .pout(pout_m), .pout_valid(valid_m), .pout_ready(pout_ready),
        .overrun(ovr_m), .ovr_clr(ovr_clr), .bit_cnt(cnt_m)
    );

    shiftreg_s2p #(.N(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sync(sync),
        .pout(pout_l), .pout_valid(valid_l), .pout_ready(pout_ready),
        .overrun(ovr_l), .ovr_clr(ovr_clr), .bit_cnt(cnt_l)
    );

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // inputs change at negedge; outputs are sampled at the following negedge
    task automatic drive(input logic en, input logic s, input logic sy);
        sin_en = en;
        sin    = s;
        sync   = sy;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_word(input string tag);
        logic [7:0] em, el;
        if (exp_m.size() == 0 || exp_l.size() == 0) begin
            check({tag, "_queue_empty"}, 8'd0, 8'd1);
        end else begin
            em = exp_m.pop_front();
            el = exp_l.pop_front();
            check({tag, "_valid_m"}, {7'd0, valid_m}, 8'd1);
            check({tag, "_valid_l"}, {7'd0, valid_l}, 8'd1);
            check({tag, "_pout_m"}, pout_m, em);
            check({tag, "_pout_l"}, pout_l, el);
        end
    endtask

    // bits go out w[7] first; optional sync on first bit, optional ready pulse on last bit
    task automatic send_word(input logic [7:0] w, input logic use_sync,
                             input logic push, input logic pulse_last);
        logic saved_ready;
        saved_ready = pout_ready;
        if (push) begin
            exp_m.push_back(w);
            exp_l.push_back(rev8(w));
        end
        for (int i = 0; i < 8; i++) begin
            if (pulse_last && i == 7) pout_ready = 1'b1;
            drive(1'b1, w[7-i], use_sync && i == 0);
            if (use_sync) check("bit_cnt", {5'd0, cnt_m}, 8'((i + 1) % 8));
        end
        pout_ready = saved_ready;
        sin_en = 1'b0;
        sync = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        check("rst_pout", pout_m, 8'h00);
        check("rst_valid", {7'd0, valid_m}, 8'd0);
        check("rst_ovr", {7'd0, ovr_m}, 8'd0);
        check("rst_cnt", {5'd0, cnt_m}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // basic word, ready high: valid for exactly one cycle
        pout_ready = 1'b1;
        send_word(8'h2A, 1'b1, 1'b1, 1'b0);
        check_word("w2a");
        check("w2a_ovr", {7'd0, ovr_m}, 8'd0);
        idle();
        check("w2a_valid_drop", {7'd0, valid_m}, 8'd0);
        check("w2a_hold", pout_m, 8'h2A);

        // backpressure and overrun
        pout_ready = 1'b0;
        send_word(8'hA5, 1'b1, 1'b1, 1'b0);
        check_word("wa5");
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        check("bp_pout_m", pout_m, 8'hA5);
        check("bp_pout_l", pout_l, 8'hA5);
        check("bp_ovr_m", {7'd0, ovr_m}, 8'd1);
        check("bp_ovr_l", {7'd0, ovr_l}, 8'd1);
        pout_ready = 1'b1;
        idle();
        check("bp_valid_drop", {7'd0, valid_m}, 8'd0);
        check("bp_ovr_sticky", {7'd0, ovr_m}, 8'd1);
        ovr_clr = 1'b1;
        idle();
        ovr_clr = 1'b0;
        check("ovr_clr", {7'd0, ovr_m}, 8'd0);

        // accept and complete in the same cycle
        pout_ready = 1'b0;
        send_word(8'h11, 1'b1, 1'b1, 1'b0);
        check_word("w11");
        send_word(8'h96, 1'b0, 1'b1, 1'b1);
        check_word("w96_same_cycle");
        check("w96_ovr", {7'd0, ovr_m}, 8'd0);
        pout_ready = 1'b1;
        idle();
        check("w96_valid_drop", {7'd0, valid_m}, 8'd0);

        // sync mid-word, and sync without a bit
        drive(1'b1, 1'b1, 1'b1);
        check("mid_cnt1", {5'd0, cnt_m}, 8'd1);
        drive(1'b1, 1'b1, 1'b0);
        check("mid_cnt2", {5'd0, cnt_m}, 8'd2);
        drive(1'b1, 1'b0, 1'b0);
        check("mid_cnt3", {5'd0, cnt_m}, 8'd3);
        drive(1'b0, 1'b1, 1'b1);
        check("sync_noen_cnt", {5'd0, cnt_m}, 8'd0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        send_word(8'hF0, 1'b1, 1'b1, 1'b0);
        check_word("wf0");
        idle();

        // build up full + overrun state, then reset asynchronously mid-word
        pout_ready = 1'b0;
        send_word(8'h5A, 1'b1, 1'b1, 1'b0);
        check_word("w5a");
        send_word(8'h00, 1'b0, 1'b0, 1'b0);
        check("pre_rst_ovr", {7'd0, ovr_m}, 8'd1);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
        check("pre_rst_cnt", {5'd0, cnt_m}, 8'd5);
        sin_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_pout_m", pout_m, 8'h00);
        check("arst_pout_l", pout_l, 8'h00);
        check("arst_valid", {7'd0, valid_m}, 8'd0);
        check("arst_ovr", {7'd0, ovr_m}, 8'd0);
        check("arst_cnt", {5'd0, cnt_m}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        pout_ready = 1'b1;
        idle();
        send_word(8'h81, 1'b0, 1'b1, 1'b0);
        check_word("w81");
        check("w81_ovr", {7'd0, ovr_m}, 8'd0);
        idle();
        check("end_valid", {7'd0, valid_m}, 8'd0);
        check("queue_drained", 8'(exp_m.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
